any1_ptw: RTL

Hardware page-table walker for the ANY-1 core. It accepts a miss notification from the four-way TLB and fetches the 64-bit page-table entry over the memory bus. A valid entry is reformatted into the TLB entry layout and written into one TLB way through the TLB table-write port. An invalid entry, or a bus error, is reported as a page fault to the core's exception logic.

---
 rtl/any1_pkg.sv | 32 +++
 rtl/any1_ptw_fmt.sv | 27 ++
 rtl/any1_ptw.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/any1_pkg.sv
// Shared ANY-1 MMU types: page-table-walker states and the 64-bit TLB entry layout.
package any1_pkg;

  localparam int PTE_G       = 62;
  localparam int PTE_ACR_LSB = 48;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_INVALID = 2'd1;
  localparam logic [1:0] CAUSE_BUSERR  = 2'd2;

  typedef enum logic [2:0] {
    PTW_IDLE,
    PTW_REQ,
    PTW_CHK,
    PTW_WRITE,
    PTW_DONE,
    PTW_FAULT
  } ptw_state_t;

  // tag and ppn are sized for the widest supported address; narrower builds zero the top bits
  typedef struct packed {
    logic [7:0]  asid;
    logic        g;
    logic        d;
    logic        a;
    logic        rsv;
    logic [3:0]  acr;
    logic [15:0] tag;
    logic [31:0] ppn;
  } tlb_entry_t;

endpackage

// File: rtl/any1_ptw_fmt.sv
// Combinational formatter turning a memory PTE plus its virtual address and ASID
// into the TLB entry layout; shared by the hardware walker and software TLB writes.
module any1_ptw_fmt
  import any1_pkg::*;
#(
  parameter int AWID = 32
) (
  input  logic [AWID-1:0] vadr_i,
  input  logic [7:0]      asid_i,
  input  logic [63:0]     pte_i,
  output tlb_entry_t      entry_o
);

  // Dirty and accessed start clear; software or the TLB sets them on first use
  always_comb begin
    entry_o                = '0;
    entry_o.asid           = asid_i;
    entry_o.g              = pte_i[PTE_G];
    entry_o.acr            = pte_i[PTE_ACR_LSB +: 4];
    entry_o.tag[AWID-25:0] = vadr_i[AWID-1:24];
    entry_o.ppn[AWID-15:0] = pte_i[AWID-15:0];
  end

  logic unused_bits;
  assign unused_bits = ^{pte_i[63], pte_i[61:52], pte_i[47:AWID-14], vadr_i[23:0]};

endmodule

// File: rtl/any1_ptw.sv
// ANY-1 hardware page-table walker: fetches one PTE per TLB miss and refills a TLB way
// round-robin. Define ANY1_PTW_STATS_EN to add walk/fault counter outputs.
module any1_ptw
  import any1_pkg::*;
#(
  parameter int AWID  = 32,
  parameter int PTE_V = 63
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            miss_i,
  input  logic [AWID-1:0] miss_adr_i,
  input  logic [7:0]      asid_i,
  input  logic [AWID-1:0] ptbr_i,
  input  logic            abort_i,
  output logic            cyc_o,
  output logic            stb_o,
  output logic [AWID-1:0] adr_o,
  input  logic            ack_i,
  input  logic            err_i,
  input  logic [63:0]     dat_i,
  output logic            tlben_o,
  output logic            wrtlb_o,
  output logic [11:0]     tlbadr_o,
  output logic [63:0]     tlbdat_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            fault_o,
  output logic [1:0]      fault_cause_o
`ifdef ANY1_PTW_STATS_EN
  ,
  output logic [31:0]     walk_cnt_o,
  output logic [31:0]     fault_cnt_o
`endif
);

  ptw_state_t      state_q, state_d;
  logic [AWID-1:0] vadr_q, vadr_d;
  logic [7:0]      asid_q, asid_d;
  logic [63:0]     pte_q, pte_d;
  logic [1:0]      way_q, way_d;
  logic [1:0]      cause_q, cause_d;
  logic            abort_q, abort_d;
  logic            aborting;
  logic [AWID-1:0] pteOff;
  tlb_entry_t      entry;

  assign aborting = abort_q | abort_i;
  assign pteOff   = {{11{1'b0}}, vadr_q[AWID-1:14], 3'b000};

  any1_ptw_fmt #(.AWID(AWID)) u_fmt (
    .vadr_i  (vadr_q),
    .asid_i  (asid_q),
    .pte_i   (pte_q),
    .entry_o (entry)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PTW_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vadr_q  <= '0;
      asid_q  <= '0;
      pte_q   <= '0;
      way_q   <= '0;
      cause_q <= CAUSE_NONE;
      abort_q <= 1'b0;
    end else begin
      vadr_q  <= vadr_d;
      asid_q  <= asid_d;
      pte_q   <= pte_d;
      way_q   <= way_d;
      cause_q <= cause_d;
      abort_q <= abort_d;
    end
  end

  // An abort seen during REQ is remembered so the bus cycle can still finish cleanly
  always_comb begin
    state_d = state_q;
    vadr_d  = vadr_q;
    asid_d  = asid_q;
    pte_d   = pte_q;
    way_d   = way_q;
    cause_d = cause_q;
    abort_d = abort_q;
    case (state_q)
      PTW_IDLE: begin
        if (miss_i && !abort_i) begin
          state_d = PTW_REQ;
          vadr_d  = miss_adr_i;
          asid_d  = asid_i;
          cause_d = CAUSE_NONE;
          abort_d = 1'b0;
        end
      end
      PTW_REQ: begin
        if (abort_i) abort_d = 1'b1;
        if (err_i) begin
          if (aborting) begin
            state_d = PTW_IDLE;
          end else begin
            state_d = PTW_FAULT;
            cause_d = CAUSE_BUSERR;
          end
        end else if (ack_i) begin
          if (aborting) begin
            state_d = PTW_IDLE;
          end else begin
            state_d = PTW_CHK;
            pte_d   = dat_i;
          end
        end
      end
      PTW_CHK: begin
        if (abort_i) begin
          state_d = PTW_IDLE;
        end else if (!pte_q[PTE_V]) begin
          state_d = PTW_FAULT;
          cause_d = CAUSE_INVALID;
        end else begin
          state_d = PTW_WRITE;
        end
      end
      PTW_WRITE: state_d = PTW_DONE;
      PTW_DONE: begin
        way_d   = way_q + 2'd1;
        state_d = PTW_IDLE;
      end
      PTW_FAULT: state_d = PTW_IDLE;
      default:   state_d = PTW_IDLE;
    endcase
  end

  always_comb begin
    cyc_o    = 1'b0;
    stb_o    = 1'b0;
    adr_o    = '0;
    tlben_o  = 1'b0;
    wrtlb_o  = 1'b0;
    tlbadr_o = '0;
    tlbdat_o = '0;
    done_o   = 1'b0;
    fault_o  = 1'b0;
    busy_o   = (state_q != PTW_IDLE);
    case (state_q)
      PTW_REQ: begin
        cyc_o = 1'b1;
        stb_o = 1'b1;
        adr_o = ptbr_i + pteOff;
      end
      PTW_WRITE: begin
        tlben_o  = 1'b1;
        wrtlb_o  = 1'b1;
        tlbadr_o = {way_q, vadr_q[23:14]};
        tlbdat_o = entry;
      end
      PTW_DONE:  done_o  = 1'b1;
      PTW_FAULT: fault_o = 1'b1;
      default: ;
    endcase
  end

  assign fault_cause_o = cause_q;

`ifdef ANY1_PTW_STATS_EN
  logic [31:0] walkCnt_q, faultCnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      walkCnt_q  <= '0;
      faultCnt_q <= '0;
    end else begin
      if (state_q == PTW_DONE)  walkCnt_q  <= walkCnt_q + 32'd1;
      if (state_q == PTW_FAULT) faultCnt_q <= faultCnt_q + 32'd1;
    end
  end

  assign walk_cnt_o  = walkCnt_q;
  assign fault_cnt_o = faultCnt_q;
`endif

endmodule
